// File: rtl/vram_arbiter_if.sv
// Screen-RAM arbiter bus bundle: video fetch, CPU I/O and single RAM port.
// slave is the arbiter's view; master is the surrounding system.
interface vram_arbiter_if #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 8,
    parameter int unsigned SW = 16
);
    logic          vid_req_i;
    logic [AW-1:0] vid_addr_i;
    logic [DW-1:0] vid_data_o;
    logic          vid_valid_o;

    logic          cpu_wr_i;
    logic          cpu_rd_i;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_dat_i;
    logic [DW-1:0] cpu_dat_o;
    logic          cpu_busy_o;
    logic          cpu_valid_o;
    logic          overrun_o;
    logic [SW-1:0] stall_cnt_o;

    logic [AW-1:0] ram_addr_o;
    logic          ram_we_o;
    logic [DW-1:0] ram_dat_o;
    logic [DW-1:0] ram_dat_i;

    modport slave (
        input  vid_req_i, vid_addr_i, cpu_wr_i, cpu_rd_i, cpu_addr_i, cpu_dat_i, ram_dat_i,
        output vid_data_o, vid_valid_o, cpu_dat_o, cpu_busy_o, cpu_valid_o, overrun_o,
               stall_cnt_o, ram_addr_o, ram_we_o, ram_dat_o
    );

    modport master (
        output vid_req_i, vid_addr_i, cpu_wr_i, cpu_rd_i, cpu_addr_i, cpu_dat_i, ram_dat_i,
        input  vid_data_o, vid_valid_o, cpu_dat_o, cpu_busy_o, cpu_valid_o, overrun_o,
               stall_cnt_o, ram_addr_o, ram_we_o, ram_dat_o
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port screen-RAM arbiter: video fetches always win, CPU ops wait
// in PEND for a free slot and expose busy/valid/overrun/stall status.
module vram_arbiter #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 8,
    parameter int unsigned SW = 16
) (
    input logic           sys_clk_i,
    input logic           sys_rst_i,
    vram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StPend, StRdata} state_e;

    state_e        state_q, state_d;
    logic          op_we_q, op_we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic [DW-1:0] cpu_dat_q, cpu_dat_d;
    logic          cpu_valid_q, cpu_valid_d;
    logic          overrun_q, overrun_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          vid_pend_q;
    logic          vid_valid_q;
    logic [DW-1:0] vid_data_q;
    logic          cpu_we;
    logic          strobe;

    assign strobe = bus.cpu_wr_i | bus.cpu_rd_i;

    always_comb begin
        state_d     = state_q;
        op_we_d     = op_we_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        cpu_dat_d   = cpu_dat_q;
        cpu_valid_d = cpu_valid_q;
        overrun_d   = overrun_q;
        stall_d     = stall_q;
        cpu_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (strobe) begin
                    // Write wins a simultaneous read; the read is dropped silently.
                    op_we_d     = bus.cpu_wr_i;
                    addr_d      = bus.cpu_addr_i;
                    wdat_d      = bus.cpu_wr_i ? bus.cpu_dat_i : wdat_q;
                    cpu_valid_d = 1'b0;
                    state_d     = StPend;
                end
            end
            StPend: begin
                if (strobe) overrun_d = 1'b1;
                if (bus.vid_req_i) begin
                    if (stall_q != '1) stall_d = stall_q + SW'(1);
                end else if (op_we_q) begin
                    cpu_we  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StRdata;
                end
            end
            StRdata: begin
                if (strobe) overrun_d = 1'b1;
                cpu_dat_d   = bus.ram_dat_i;
                cpu_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Video owns the port whenever it asks; the CPU only drives it from PEND otherwise.
    assign bus.ram_addr_o  = bus.vid_req_i ? bus.vid_addr_i : addr_q;
    assign bus.ram_we_o    = cpu_we & ~sys_rst_i;
    assign bus.ram_dat_o   = wdat_q;

    assign bus.vid_data_o  = vid_data_q;
    assign bus.vid_valid_o = vid_valid_q;
    assign bus.cpu_dat_o   = cpu_dat_q;
    assign bus.cpu_busy_o  = (state_q != StIdle);
    assign bus.cpu_valid_o = cpu_valid_q;
    assign bus.overrun_o   = overrun_q;
    assign bus.stall_cnt_o = stall_q;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q     <= StIdle;
            op_we_q     <= 1'b0;
            addr_q      <= '0;
            wdat_q      <= '0;
            cpu_dat_q   <= '0;
            cpu_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            stall_q     <= '0;
            vid_pend_q  <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_we_q     <= op_we_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            cpu_dat_q   <= cpu_dat_d;
            cpu_valid_q <= cpu_valid_d;
            overrun_q   <= overrun_d;
            stall_q     <= stall_d;
            vid_pend_q  <= bus.vid_req_i;
            vid_valid_q <= vid_pend_q;
            if (vid_pend_q) vid_data_q <= bus.ram_dat_i;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM.
// RAM preload: byte at address a is a[7:0] ^ 8'h3C.
module tb_vram_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    vram_arbiter_if #(.AW(13), .DW(8), .SW(16)) bus ();

    vram_arbiter #(.AW(13), .DW(8), .SW(16)) dut (
        .sys_clk_i(clk),
        .sys_rst_i(rst),
        .bus      (bus)
    );

    logic [7:0] mem [0:8191];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read-before-write synchronous RAM.
    always @(posedge clk) begin
        bus.ram_dat_i <= mem[bus.ram_addr_o];
        if (bus.ram_we_o) mem[bus.ram_addr_o] = bus.ram_dat_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a read strobe and land one step into the cycle where the result is visible.
    task automatic cpu_read(input logic [12:0] a);
        bus.cpu_rd_i   = 1'b1;
        bus.cpu_addr_i = a;
        tick();
        bus.cpu_rd_i = 1'b0;
        tick();
        tick();
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_vid_data"}, 32'(bus.vid_data_o), 32'h0);
        chk({pfx, "_vid_valid"}, 32'(bus.vid_valid_o), 32'h0);
        chk({pfx, "_cpu_dat"}, 32'(bus.cpu_dat_o), 32'h0);
        chk({pfx, "_busy"}, 32'(bus.cpu_busy_o), 32'h0);
        chk({pfx, "_cpu_valid"}, 32'(bus.cpu_valid_o), 32'h0);
        chk({pfx, "_overrun"}, 32'(bus.overrun_o), 32'h0);
        chk({pfx, "_stall"}, 32'(bus.stall_cnt_o), 32'h0);
        chk({pfx, "_ram_we"}, 32'(bus.ram_we_o), 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h3C;
        bus.vid_req_i  = 1'b0;
        bus.vid_addr_i = '0;
        bus.cpu_wr_i   = 1'b0;
        bus.cpu_rd_i   = 1'b0;
        bus.cpu_addr_i = '0;
        bus.cpu_dat_i  = '0;
        rst = 1'b1;
        tick();
        tick();
        #1;
        chk_reset_vals("por");
        rst = 1'b0;

        // Uncontended write of 0xA5 to 0x1234, then read it back.
        bus.cpu_wr_i   = 1'b1;
        bus.cpu_addr_i = 13'h1234;
        bus.cpu_dat_i  = 8'hA5;
        #1;
        chk("wr_a_busy", 32'(bus.cpu_busy_o), 32'h0);
        tick();
        bus.cpu_wr_i = 1'b0;
        #1;
        chk("wr_a1_we", 32'(bus.ram_we_o), 32'h1);
        chk("wr_a1_addr", 32'(bus.ram_addr_o), 32'h1234);
        chk("wr_a1_dat", 32'(bus.ram_dat_o), 32'hA5);
        chk("wr_a1_busy", 32'(bus.cpu_busy_o), 32'h1);
        tick();
        #1;
        chk("wr_a2_busy", 32'(bus.cpu_busy_o), 32'h0);
        chk("wr_a2_we", 32'(bus.ram_we_o), 32'h0);

        bus.cpu_rd_i   = 1'b1;
        bus.cpu_addr_i = 13'h1234;
        tick();
        bus.cpu_rd_i = 1'b0;
        #1;
        chk("rd_a1_busy", 32'(bus.cpu_busy_o), 32'h1);
        chk("rd_a1_addr", 32'(bus.ram_addr_o), 32'h1234);
        tick();
        #1;
        chk("rd_a2_busy", 32'(bus.cpu_busy_o), 32'h1);
        chk("rd_a2_valid", 32'(bus.cpu_valid_o), 32'h0);
        tick();
        #1;
        chk("rd_a3_valid", 32'(bus.cpu_valid_o), 32'h1);
        chk("rd_a3_dat", 32'(bus.cpu_dat_o), 32'hA5);
        chk("rd_a3_busy", 32'(bus.cpu_busy_o), 32'h0);

        // CPU read of 0x0100 pending behind 10 back-to-back video fetches at 0x0200+j.
        bus.cpu_rd_i   = 1'b1;
        bus.cpu_addr_i = 13'h0100;
        tick();
        bus.cpu_rd_i = 1'b0;
        for (int j = 0; j < 13; j++) begin
            bus.vid_req_i  = (j < 10);
            bus.vid_addr_i = 13'h0200 + 13'(j);
            #1;
            if (j == 0) begin
                chk("cont_valid_clr", 32'(bus.cpu_valid_o), 32'h0);
                chk("cont_vid_addr", 32'(bus.ram_addr_o), 32'h0200);
            end
            if (j >= 2 && j < 12) begin
                chk($sformatf("cont_vvalid_%0d", j), 32'(bus.vid_valid_o), 32'h1);
                chk($sformatf("cont_vdata_%0d", j), 32'(bus.vid_data_o),
                    32'(8'(j - 2) ^ 8'h3C));
            end else begin
                chk($sformatf("cont_vidle_%0d", j), 32'(bus.vid_valid_o), 32'h0);
            end
            if (j == 10) begin
                chk("cont_cpu_addr", 32'(bus.ram_addr_o), 32'h0100);
                chk("cont_stall", 32'(bus.stall_cnt_o), 32'd10);
            end
            if (j == 12) begin
                chk("cont_cpu_valid", 32'(bus.cpu_valid_o), 32'h1);
                chk("cont_cpu_dat", 32'(bus.cpu_dat_o), 32'h3C);
                chk("cont_busy", 32'(bus.cpu_busy_o), 32'h0);
            end
            tick();
        end
        bus.vid_req_i  = 1'b0;
        bus.vid_addr_i = '0;

        // Video fetch of 0x0456 overlapping the RDATA cycle of a CPU read of 0x0345.
        bus.cpu_rd_i   = 1'b1;
        bus.cpu_addr_i = 13'h0345;
        tick();
        bus.cpu_rd_i = 1'b0;
        #1;
        chk("ovl_cpu_addr", 32'(bus.ram_addr_o), 32'h0345);
        tick();
        bus.vid_req_i  = 1'b1;
        bus.vid_addr_i = 13'h0456;
        #1;
        chk("ovl_vid_addr", 32'(bus.ram_addr_o), 32'h0456);
        chk("ovl_busy", 32'(bus.cpu_busy_o), 32'h1);
        tick();
        bus.vid_req_i = 1'b0;
        #1;
        chk("ovl_cpu_valid", 32'(bus.cpu_valid_o), 32'h1);
        chk("ovl_cpu_dat", 32'(bus.cpu_dat_o), 32'h79);
        tick();
        #1;
        chk("ovl_vid_valid", 32'(bus.vid_valid_o), 32'h1);
        chk("ovl_vid_data", 32'(bus.vid_data_o), 32'h6A);
        chk("ovl_cpu_hold", 32'(bus.cpu_dat_o), 32'h79);
        chk("ovl_stall", 32'(bus.stall_cnt_o), 32'd10);

        // Write strobe to 0x0020 while a write to 0x0010 is in flight.
        bus.cpu_wr_i   = 1'b1;
        bus.cpu_addr_i = 13'h0010;
        bus.cpu_dat_i  = 8'h5A;
        #1;
        chk("ovr_before", 32'(bus.overrun_o), 32'h0);
        tick();
        bus.cpu_addr_i = 13'h0020;
        bus.cpu_dat_i  = 8'hFF;
        #1;
        chk("ovr_we", 32'(bus.ram_we_o), 32'h1);
        chk("ovr_addr", 32'(bus.ram_addr_o), 32'h0010);
        chk("ovr_dat", 32'(bus.ram_dat_o), 32'h5A);
        tick();
        bus.cpu_wr_i = 1'b0;
        #1;
        chk("ovr_set", 32'(bus.overrun_o), 32'h1);
        chk("ovr_busy", 32'(bus.cpu_busy_o), 32'h0);
        tick();
        tick();
        #1;
        chk("ovr_sticky", 32'(bus.overrun_o), 32'h1);
        cpu_read(13'h0010);
        chk("ovr_first_done", 32'(bus.cpu_dat_o), 32'h5A);
        cpu_read(13'h0020);
        chk("ovr_second_dropped", 32'(bus.cpu_dat_o), 32'h1C);
        chk("ovr_still", 32'(bus.overrun_o), 32'h1);

        // Simultaneous write and read strobes: write of 0x77 to 0x0030 only.
        bus.cpu_wr_i   = 1'b1;
        bus.cpu_rd_i   = 1'b1;
        bus.cpu_addr_i = 13'h0030;
        bus.cpu_dat_i  = 8'h77;
        tick();
        bus.cpu_wr_i = 1'b0;
        bus.cpu_rd_i = 1'b0;
        #1;
        chk("both_valid_clr", 32'(bus.cpu_valid_o), 32'h0);
        chk("both_we", 32'(bus.ram_we_o), 32'h1);
        chk("both_addr", 32'(bus.ram_addr_o), 32'h0030);
        tick();
        #1;
        chk("both_busy", 32'(bus.cpu_busy_o), 32'h0);
        tick();
        #1;
        chk("both_no_valid", 32'(bus.cpu_valid_o), 32'h0);
        chk("both_dat_hold", 32'(bus.cpu_dat_o), 32'h1C);
        cpu_read(13'h0030);
        chk("both_readback", 32'(bus.cpu_dat_o), 32'h77);

        // Reset while a write of 0x99 to 0x0040 sits in PEND.
        bus.vid_req_i  = 1'b1;
        bus.vid_addr_i = 13'h0500;
        bus.cpu_wr_i   = 1'b1;
        bus.cpu_addr_i = 13'h0040;
        bus.cpu_dat_i  = 8'h99;
        tick();
        bus.cpu_wr_i  = 1'b0;
        bus.vid_req_i = 1'b0;
        #1;
        chk("rst_pend_busy", 32'(bus.cpu_busy_o), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_no_we", 32'(bus.ram_we_o), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk_reset_vals("mid");
        cpu_read(13'h0040);
        chk("rst_no_write", 32'(bus.cpu_dat_o), 32'h7C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port screen-RAM arbiter between the ZX video fetch path and the J1 CPU I/O path. Each cycle the single synchronous RAM port serves exactly one requester. Video fetches have absolute priority so the raster is never corrupted. CPU reads and writes arrive as one-cycle strobes from the I/O decoder; the block holds them pending until a free slot and reports busy/valid status for the CPU to poll.

## Interface
Parameters:
- AW, 13: RAM address width (6912-byte ZX screen fits).
- DW, 8: RAM data width.
- SW, 16: stall-counter width.

Ports:
- sys_clk_i  in  1  system clock; all logic on rising edge.
- sys_rst_i  in  1  reset; synchronous, active-high.
- vid_req_i  in  1  video fetch request, one per cycle max.
- vid_addr_i  in  AW  video fetch address, valid with vid_req_i.
- vid_data_o  out  DW  fetched byte.
- vid_valid_o  out  1  one-cycle pulse; vid_data_o valid.
- cpu_wr_i  in  1  CPU write strobe (1 cycle).
- cpu_rd_i  in  1  CPU read strobe (1 cycle).
- cpu_addr_i  in  AW  CPU address, sampled with a strobe.
- cpu_dat_i  in  DW  CPU write data, sampled with cpu_wr_i.
- cpu_dat_o  out  DW  last CPU read result, held.
- cpu_busy_o  out  1  CPU operation pending or in flight.
- cpu_valid_o  out  1  cpu_dat_o holds a fresh read result.
- overrun_o  out  1  sticky: a strobe arrived while busy.
- stall_cnt_o  out  SW  saturating count of cycles a pending CPU op lost the port to video.
- ram_addr_o  out  AW  RAM address (combinational from grant).
- ram_we_o  out  1  RAM write enable (combinational).
- ram_dat_o  out  DW  RAM write data (combinational).
- ram_dat_i  in  DW  RAM read data, valid the cycle after the address.

## Operation
- FSM states: IDLE, PEND, RDATA. Reset -> IDLE.
- IDLE: cpu_wr_i or cpu_rd_i latches address, data and op; next state PEND. If both are high, the write wins and the read is discarded without setting overrun_o.
- PEND: if vid_req_i is high, video is granted, the state stays PEND and stall_cnt_o increments (saturating at all-ones). If vid_req_i is low, the CPU is granted.
  - CPU write granted: ram_we_o=1; next state IDLE.
  - CPU read granted: next state RDATA.
- RDATA: ram_dat_i is captured into cpu_dat_o and cpu_valid_o is set; next state IDLE. The port is free in this cycle, so a video request is granted normally (data phase overlaps the next address phase).
- Video grant: ram_addr_o=vid_addr_i, ram_we_o=0. A one-bit pipeline flag marks the issued read. ram_dat_i is registered into vid_data_o next cycle and vid_valid_o pulses.
- No grant: ram_we_o=0; ram_addr_o and ram_dat_o hold the latched CPU values (don't-care).
- cpu_busy_o = (state != IDLE).
- cpu_valid_o clears on the edge that accepts a new strobe; cpu_dat_o holds its value until the next read completes.
- A strobe in PEND or RDATA is ignored and sets overrun_o. overrun_o clears only on reset.
- Reset mid-operation drops any pending CPU op; no RAM write is issued in the reset cycle.
- Reset values: vid_data_o=0, vid_valid_o=0, cpu_dat_o=0, cpu_busy_o=0, cpu_valid_o=0, overrun_o=0, stall_cnt_o=0, ram_we_o=0.

## Timing
- Grant cycle G: RAM control is driven combinationally in G; read data appears on the output at G+2 (vid_valid_o pulse, or cpu_valid_o rising).
- CPU strobe accepted in cycle A with no video contention:
  - write: RAM written in A+1; busy in A+1 only.
  - read: address in A+1, RDATA in A+2, cpu_valid_o and cpu_dat_o valid from A+3; busy in A+1..A+2.
- Each contended cycle adds exactly one cycle of delay and one stall count.
- Video throughput: one access per cycle, never delayed, latency fixed at 2.
- Maximum CPU wait is unbounded if vid_req_i stays high; stall_cnt_o exposes this.

## Test plan
- Write 0xA5 to 0x1234 (AW=13 -> 0x1234), idle video: ram_we_o=1 with ram_addr_o=0x1234 in A+1; busy high only in A+1; read back gives cpu_dat_o=0xA5, cpu_valid_o=1 at A+3.
- Continuous vid_req_i for 10 cycles with a CPU read pending: 10 vid_valid_o pulses with correct data, CPU granted in the first free cycle, stall_cnt_o=10.
- Video request during RDATA: video granted that cycle; cpu_dat_o gets the CPU byte and vid_data_o the video byte, no mixing.
- Strobe while busy: overrun_o=1 and stays 1; the original op completes unaffected; the second op is never executed.
- Simultaneous cpu_wr_i and cpu_rd_i: only the write executes, cpu_valid_o stays 0.
- Assert sys_rst_i in PEND with a write latched: no RAM write occurs; all outputs return to reset values the next cycle.
